qsyscpu_onchip_memory3_dp: RTL and testbench
============================================

Name: qsyscpu_onchip_memory3_dp

Overview:
- Parametrised true-dual-port on-chip RAM for the qsyscpu system.
- Presents two independent Avalon-MM slaves: s1 for the CPU data master, s2 for DMA or a second master.
- Successor to the fixed 16-bit x 2048 single-port unregistered memory. Adds configurable width and depth, a registered read pipeline with readdatavalid, a freeze write-protect mode, deterministic collision rules and out-of-range handling.

Parameters:
- DATA_W, 32: data width in bits; must be a multiple of 8.
- DEPTH, 4096: number of words; need not be a power of 2.
- ADDR_W, $clog2(DEPTH): word address width.
- READ_LATENCY, 1: read latency in cycles; legal values 1 or 2 (2 adds an output register).
- INIT_FILE, "onchip_mem.hex": $readmemh image; an empty string means no initialisation.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clken  in  1  global clock enable
- reset_req  in  1  reset-request quiesce; effective enable is clocken = clken & ~reset_req
- freeze  in  1  write protect; while high all writes are dropped, reads continue
- s1_address  in  ADDR_W  port 1 word address
- s1_byteenable  in  DATA_W/8  port 1 byte lanes
- s1_chipselect  in  1  port 1 select
- s1_read  in  1  port 1 read strobe
- s1_write  in  1  port 1 write strobe
- s1_writedata  in  DATA_W  port 1 write data
- s1_readdata  out  DATA_W  port 1 read data
- s1_readdatavalid  out  1  port 1 read data valid
- s2_*: identical set to s1_* for port 2.

Behaviour:
- Storage: DEPTH x DATA_W array. Contents are not affected by reset.
- Accept rule: a port accepts one command per cycle when clocken & chipselect.
  - write: if freeze=0 and address<DEPTH, each lane with byteenable=1 is updated at the clock edge.
  - read & ~write: issue a read.
  - read & write together: the write is performed, the read is ignored, and no readdatavalid is produced.
- Read latency: s*_readdatavalid=1 exactly READ_LATENCY enabled cycles after an accepted read. readdata holds the word value from before any same-cycle write (old-data semantics) on both the same port and the mixed port.
- Out of range (address >= DEPTH): writes are dropped; reads return all-zero data with readdatavalid still asserted.
- Clock-enable stall: while clocken=0:
  - no commands are accepted;
  - pipeline stages (data and valid) hold their values;
  - readdatavalid is forced to 0.
  - When clocken returns high, the held result is presented exactly once.
- Write collision: both ports write the same address in the same cycle. Per byte lane, s1 wins where s1_byteenable=1; otherwise s2's enabled lanes are written.
- Pipeline contents between valid pulses: readdata holds its last value.
- Reset:
  - all readdata registers clear to 0, all readdatavalid to 0;
  - all in-flight reads are discarded, with no valid produced for them even if reset deasserts the next cycle;
  - a command presented during reset is ignored.
- Ports are fully independent; each sustains one read per cycle (throughput 1).

Optional Feature:
- Macro: ONCHIP_MEM_PARITY_EN.
- Defined:
  - one even-parity bit is stored per byte, written with its lane;
  - on read, parity is recomputed per lane;
  - extra outputs s1_parity_err / s2_parity_err (1 bit each) assert together with readdatavalid when any lane mismatches;
  - out-of-range reads report no error;
  - a test-only input inject_parity_flip (1 bit) inverts the stored parity of lane 0 on writes.
- Undefined: no parity storage and none of these ports.

Decomposition:
- Package qsyscpu_onchip_mem_pkg:
  - localparam for max READ_LATENCY (2);
  - function byte_parity(byte) returning 1 bit;
  - typedef rd_stage_t {logic valid; logic [DATA_W-1:0] data; logic perr}, parameterised via the module's DATA_W. Use a struct in the sub-module if package typing is impractical.
- Sub-module qsyscpu_onchip_mem_rdpipe:
  - per-port read pipeline implementing latency, stall hold and reset flush;
  - instantiated twice, once per port.

Test Plan:
- Write, then read:
  - s1 writes 0xDEADBEEF to addr 5 with be=0xF, then s1 reads addr 5 → readdatavalid one cycle later (READ_LATENCY=1), readdata=0xDEADBEEF.
  - With READ_LATENCY=2 → valid two cycles later.
- Byte lanes: write 0x11223344 with be=0x5 over 0xFFFFFFFF → read returns 0xFF22FF44.
- Collision: s1 writes 0xAAAAAAAA with be=0x3 and s2 writes 0xBBBBBBBB with be=0xF to addr 9 in the same cycle → read returns 0xBBBBAAAA. In the same cycle, s2 reading addr 9 returns the prior value.
- Stall and freeze:
  - accept a read, drop clken for 3 cycles → no valid during the stall; exactly one valid with correct data on the first cycle after clken=1.
  - writes with freeze=1 leave memory unchanged.
- Reset and range:
  - assert reset the cycle after a read is accepted → no readdatavalid ever appears for it; readdata=0.
  - With DEPTH=3000, reading addr 3500 → valid with data 0; writing addr 3500 changes nothing.
- Parity (ONCHIP_MEM_PARITY_EN):
  - write with inject_parity_flip=1, then read → s1_parity_err=1 together with valid.
  - Normal write, then read → 0.

Source files
------------

// File: rtl/qsyscpu_onchip_mem_pkg.sv
// Shared definitions for the qsyscpu dual-port on-chip RAM.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package qsyscpu_onchip_mem_pkg;

   // Deepest read pipeline supported: array read stage plus one output register.
   localparam int RD_LAT_MAX = 2;

   // Even-parity bit for one byte: the byte plus this bit always holds an even count of ones.
   function automatic logic byte_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/qsyscpu_onchip_mem_rdpipe.sv
// Per-port read pipeline: carries read data (and parity status) from issue to readdatavalid.
// Latency: READ_LATENCY (1 or 2) enabled cycles from an issued read to readdatavalid.
// Backpressure: none; clocken low freezes every stage and masks readdatavalid until it returns.
module qsyscpu_onchip_mem_rdpipe
   import qsyscpu_onchip_mem_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clocken,
   input  logic              rd_issue,
   input  logic [DATA_W-1:0] rd_data,
`ifdef ONCHIP_MEM_PARITY_EN
   input  logic              rd_perr,
   output logic              parity_err,
`endif
   output logic [DATA_W-1:0] readdata,
   output logic              readdatavalid
);

   typedef struct {
      logic              valid;
      logic [DATA_W-1:0] data;
      logic              perr;
   } rd_stage_t;

   rd_stage_t st1_q;
   rd_stage_t out_st;
   logic      in_perr;

   if (READ_LATENCY < 1 || READ_LATENCY > RD_LAT_MAX) begin : g_bad_latency
      $error("qsyscpu_onchip_mem_rdpipe: READ_LATENCY must be 1 or 2");
   end

`ifdef ONCHIP_MEM_PARITY_EN
   assign in_perr = rd_perr;
`else
   assign in_perr = 1'b0;
`endif

   // First stage: captures the array word on an issued read; data only moves with a valid entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         st1_q.valid <= 1'b0;
         st1_q.data  <= '0;
         st1_q.perr  <= 1'b0;
      end else if (clocken) begin
         st1_q.valid <= rd_issue;
         if (rd_issue) begin
            st1_q.data <= rd_data;
            st1_q.perr <= in_perr;
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      rd_stage_t st2_q;

      // Output register stage: advances only when an enabled cycle carries a valid entry.
      always_ff @(posedge clk) begin
         if (reset) begin
            st2_q.valid <= 1'b0;
            st2_q.data  <= '0;
            st2_q.perr  <= 1'b0;
         end else if (clocken) begin
            st2_q.valid <= st1_q.valid;
            if (st1_q.valid) begin
               st2_q.data <= st1_q.data;
               st2_q.perr <= st1_q.perr;
            end
         end
      end

      assign out_st = st2_q;
   end else begin : g_lat1
      assign out_st = st1_q;
   end

   // A held result is shown only on an enabled, non-reset cycle, so a stall presents it exactly once
   // and a read caught by reset never surfaces.
   assign readdatavalid = out_st.valid & clocken & ~reset;
   assign readdata      = out_st.data;

`ifdef ONCHIP_MEM_PARITY_EN
   assign parity_err = out_st.perr & readdatavalid;
`endif

endmodule

// File: rtl/qsyscpu_onchip_memory3_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slaves (s1 CPU data, s2 DMA); optional byte parity via ONCHIP_MEM_PARITY_EN.
// Latency: READ_LATENCY (1 or 2) enabled cycles from an accepted read to readdatavalid; writes land at the accepting edge.
// Backpressure: none, one command per port per cycle; clken low or reset_req high stalls both ports and holds read results.
module qsyscpu_onchip_memory3_dp
   import qsyscpu_onchip_mem_pkg::*;
#(
   parameter int    DATA_W       = 32,
   parameter int    DEPTH        = 4096,
   parameter int    ADDR_W       = $clog2(DEPTH),
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = "onchip_mem.hex"
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clken,
   input  logic                  reset_req,
   input  logic                  freeze,
`ifdef ONCHIP_MEM_PARITY_EN
   input  logic                  inject_parity_flip,
   output logic                  s1_parity_err,
   output logic                  s2_parity_err,
`endif
   input  logic [ADDR_W-1:0]     s1_address,
   input  logic [DATA_W/8-1:0]   s1_byteenable,
   input  logic                  s1_chipselect,
   input  logic                  s1_read,
   input  logic                  s1_write,
   input  logic [DATA_W-1:0]     s1_writedata,
   output logic [DATA_W-1:0]     s1_readdata,
   output logic                  s1_readdatavalid,
   input  logic [ADDR_W-1:0]     s2_address,
   input  logic [DATA_W/8-1:0]   s2_byteenable,
   input  logic                  s2_chipselect,
   input  logic                  s2_read,
   input  logic                  s2_write,
   input  logic [DATA_W-1:0]     s2_writedata,
   output logic [DATA_W-1:0]     s2_readdata,
   output logic                  s2_readdatavalid
);

   localparam int              NB      = DATA_W / 8;
   // One extra bit so the range check also works when DEPTH fills the whole address space.
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   if (DATA_W % 8 != 0) begin : g_bad_width
      $error("qsyscpu_onchip_memory3_dp: DATA_W must be a multiple of 8 (image %s)", INIT_FILE);
   end

   logic              clocken;
   logic              s1_acc, s1_in_range, s1_wr, s1_rd;
   logic              s2_acc, s2_in_range, s2_wr, s2_rd;
   logic [DATA_W-1:0] s1_rd_word, s2_rd_word;
   logic [DATA_W-1:0] mem [DEPTH];

   assign clocken = clken & ~reset_req;

   // Command acceptance: reset and a stalled clock both swallow whatever is presented.
   assign s1_acc      = clocken & s1_chipselect & ~reset;
   assign s1_in_range = ({1'b0, s1_address} < DEPTH_C);
   assign s1_wr       = s1_acc & s1_write & ~freeze & s1_in_range;
   assign s1_rd       = s1_acc & s1_read & ~s1_write;

   assign s2_acc      = clocken & s2_chipselect & ~reset;
   assign s2_in_range = ({1'b0, s2_address} < DEPTH_C);
   assign s2_wr       = s2_acc & s2_write & ~freeze & s2_in_range;
   assign s2_rd       = s2_acc & s2_read & ~s2_write;

   // Byte-lane writes; s1 is applied last so it wins any lane both ports enable at the same address.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (s2_wr && s2_byteenable[i])
            mem[s2_address][8*i +: 8] <= s2_writedata[8*i +: 8];
         if (s1_wr && s1_byteenable[i])
            mem[s1_address][8*i +: 8] <= s1_writedata[8*i +: 8];
      end
   end

   // Port 1 array read, sampled before this edge's writes (old data); out-of-range reads return zero.
   always_comb begin
      s1_rd_word = '0;
      if (s1_in_range)
         s1_rd_word = mem[s1_address];
   end

   // Port 2 array read, same old-data and out-of-range rules as port 1.
   always_comb begin
      s2_rd_word = '0;
      if (s2_in_range)
         s2_rd_word = mem[s2_address];
   end

`ifdef ONCHIP_MEM_PARITY_EN
   logic [NB-1:0] par [DEPTH];
   logic          s1_rd_perr, s2_rd_perr;

   // Parity bits follow their data lanes, including the s1-wins collision rule; lane 0 can be corrupted on demand.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (s2_wr && s2_byteenable[i])
            par[s2_address][i] <= byte_parity(s2_writedata[8*i +: 8]) ^ (inject_parity_flip && (i == 0));
         if (s1_wr && s1_byteenable[i])
            par[s1_address][i] <= byte_parity(s1_writedata[8*i +: 8]) ^ (inject_parity_flip && (i == 0));
      end
   end

   // Port 1 parity recheck of every lane; out-of-range reads never flag an error.
   always_comb begin
      s1_rd_perr = 1'b0;
      if (s1_in_range) begin
         for (int i = 0; i < NB; i++) begin
            if (byte_parity(s1_rd_word[8*i +: 8]) != par[s1_address][i])
               s1_rd_perr = 1'b1;
         end
      end
   end

   // Port 2 parity recheck, same rules as port 1.
   always_comb begin
      s2_rd_perr = 1'b0;
      if (s2_in_range) begin
         for (int i = 0; i < NB; i++) begin
            if (byte_parity(s2_rd_word[8*i +: 8]) != par[s2_address][i])
               s2_rd_perr = 1'b1;
         end
      end
   end
`endif

   qsyscpu_onchip_mem_rdpipe #(
      .DATA_W       (DATA_W),
      .READ_LATENCY (READ_LATENCY)
   ) u_s1_rdpipe (
      .clk           (clk),
      .reset         (reset),
      .clocken       (clocken),
      .rd_issue      (s1_rd),
      .rd_data       (s1_rd_word),
`ifdef ONCHIP_MEM_PARITY_EN
      .rd_perr       (s1_rd_perr),
      .parity_err    (s1_parity_err),
`endif
      .readdata      (s1_readdata),
      .readdatavalid (s1_readdatavalid)
   );

   qsyscpu_onchip_mem_rdpipe #(
      .DATA_W       (DATA_W),
      .READ_LATENCY (READ_LATENCY)
   ) u_s2_rdpipe (
      .clk           (clk),
      .reset         (reset),
      .clocken       (clocken),
      .rd_issue      (s2_rd),
      .rd_data       (s2_rd_word),
`ifdef ONCHIP_MEM_PARITY_EN
      .rd_perr       (s2_rd_perr),
      .parity_err    (s2_parity_err),
`endif
      .readdata      (s2_readdata),
      .readdatavalid (s2_readdatavalid)
   );

endmodule

// File: tb/tb_qsyscpu_onchip_memory3_dp.sv
// Directed bench for the dual-port on-chip RAM: instance A (DEPTH 3000, latency 1), instance B (DEPTH 16, latency 2).
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_qsyscpu_onchip_memory3_dp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, clken, reset_req, freeze;

   logic [11:0] a1_addr, a2_addr;
   logic [3:0]  a1_be, a2_be;
   logic        a1_cs, a1_rd, a1_wr, a2_cs, a2_rd, a2_wr;
   logic [31:0] a1_wd, a2_wd, a1_rdat, a2_rdat;
   logic        a1_rdv, a2_rdv;

   logic [3:0]  b1_addr, b2_addr;
   logic [3:0]  b1_be, b2_be;
   logic        b1_cs, b1_rd, b1_wr, b2_cs, b2_rd, b2_wr;
   logic [31:0] b1_wd, b2_wd, b1_rdat, b2_rdat;
   logic        b1_rdv, b2_rdv;

   int n_assert;
   int n_fail;

   qsyscpu_onchip_memory3_dp #(
      .DATA_W(32), .DEPTH(3000), .ADDR_W(12), .READ_LATENCY(1), .INIT_FILE("")
   ) u_dut_a (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .freeze(freeze),
      .s1_address(a1_addr), .s1_byteenable(a1_be), .s1_chipselect(a1_cs), .s1_read(a1_rd),
      .s1_write(a1_wr), .s1_writedata(a1_wd), .s1_readdata(a1_rdat), .s1_readdatavalid(a1_rdv),
      .s2_address(a2_addr), .s2_byteenable(a2_be), .s2_chipselect(a2_cs), .s2_read(a2_rd),
      .s2_write(a2_wr), .s2_writedata(a2_wd), .s2_readdata(a2_rdat), .s2_readdatavalid(a2_rdv)
   );

   qsyscpu_onchip_memory3_dp #(
      .DATA_W(32), .DEPTH(16), .ADDR_W(4), .READ_LATENCY(2), .INIT_FILE("")
   ) u_dut_b (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .freeze(freeze),
      .s1_address(b1_addr), .s1_byteenable(b1_be), .s1_chipselect(b1_cs), .s1_read(b1_rd),
      .s1_write(b1_wr), .s1_writedata(b1_wd), .s1_readdata(b1_rdat), .s1_readdatavalid(b1_rdv),
      .s2_address(b2_addr), .s2_byteenable(b2_be), .s2_chipselect(b2_cs), .s2_read(b2_rd),
      .s2_write(b2_wr), .s2_writedata(b2_wd), .s2_readdata(b2_rdat), .s2_readdatavalid(b2_rdv)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a1_cmd(input logic rd, input logic wr, input logic [11:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
      a1_cs = rd | wr; a1_rd = rd; a1_wr = wr; a1_addr = addr; a1_be = be; a1_wd = wd;
   endtask

   task automatic a2_cmd(input logic rd, input logic wr, input logic [11:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
      a2_cs = rd | wr; a2_rd = rd; a2_wr = wr; a2_addr = addr; a2_be = be; a2_wd = wd;
   endtask

   task automatic b1_cmd(input logic rd, input logic wr, input logic [3:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
      b1_cs = rd | wr; b1_rd = rd; b1_wr = wr; b1_addr = addr; b1_be = be; b1_wd = wd;
   endtask

   task automatic idle_all();
      a1_cmd(1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
      a2_cmd(1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
      b1_cmd(1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
      b2_cs = 1'b0; b2_rd = 1'b0; b2_wr = 1'b0; b2_addr = 4'd0; b2_be = 4'h0; b2_wd = 32'h0;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset = 1'b1; clken = 1'b1; reset_req = 1'b0; freeze = 1'b0;
      idle_all();
      tick(); tick();

      // Reset state
      @(negedge clk);
      check("rst_a1_vld", 32'(a1_rdv), 32'd0);
      check("rst_a1_dat", a1_rdat, 32'h0);
      check("rst_a2_vld", 32'(a2_rdv), 32'd0);
      check("rst_a2_dat", a2_rdat, 32'h0);
      check("rst_b1_dat", b1_rdat, 32'h0);
      tick();
      reset = 1'b0;

      // Write then read, latency 1
      a1_cmd(1'b0, 1'b1, 12'd5, 4'hF, 32'hDEADBEEF); tick();
      a1_cmd(1'b1, 1'b0, 12'd5, 4'h0, 32'h0);
      @(negedge clk); check("l1_issue_vld", 32'(a1_rdv), 32'd0); tick();
      a1_cmd(1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
      @(negedge clk);
      check("l1_vld", 32'(a1_rdv), 32'd1);
      check("l1_dat", a1_rdat, 32'hDEADBEEF);
      tick();
      @(negedge clk); check("l1_single_pulse", 32'(a1_rdv), 32'd0); tick();

      // Byte lanes
      a1_cmd(1'b0, 1'b1, 12'd6, 4'hF, 32'hFFFFFFFF); tick();
      a1_cmd(1'b0, 1'b1, 12'd6, 4'h5, 32'h11223344); tick();
      a1_cmd(1'b1, 1'b0, 12'd6, 4'h0, 32'h0); tick();
      a1_cmd(1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
      @(negedge clk); check("byte_lanes", a1_rdat, 32'hFF22FF44); tick();

      // Collision at addr 9, then a mixed-port read observing old data
      a2_cmd(1'b0, 1'b1, 12'd9, 4'hF, 32'h12345678); tick();
      a1_cmd(1'b0, 1'b1, 12'd9, 4'h3, 32'hAAAAAAAA);
      a2_cmd(1'b0, 1'b1, 12'd9, 4'hF, 32'hBBBBBBBB); tick();
      a1_cmd(1'b0, 1'b1, 12'd9, 4'hF, 32'hCAFEF00D);
      a2_cmd(1'b1, 1'b0, 12'd9, 4'h0, 32'h0); tick();
      idle_all();
      @(negedge clk);
      check("mixed_vld", 32'(a2_rdv), 32'd1);
      check("collision_old_dat", a2_rdat, 32'hBBBBAAAA);
      tick();
      a1_cmd(1'b1, 1'b0, 12'd9, 4'h0, 32'h0); tick();
      idle_all();
      @(negedge clk); check("mixed_new_dat", a1_rdat, 32'hCAFEF00D); tick();

      // Read and write together: write happens, no valid
      a1_cmd(1'b1, 1'b1, 12'd10, 4'hF, 32'h00000055); tick();
      idle_all();
      @(negedge clk); check("rw_no_vld", 32'(a1_rdv), 32'd0); tick();
      a1_cmd(1'b1, 1'b0, 12'd10, 4'h0, 32'h0); tick();
      idle_all();
      @(negedge clk); check("rw_write_done", a1_rdat, 32'h00000055); tick();

      // Clock-enable stall for 3 cycles; a write presented meanwhile must be ignored
      a1_cmd(1'b1, 1'b0, 12'd5, 4'h0, 32'h0); tick();
      clken = 1'b0;
      a1_cmd(1'b0, 1'b1, 12'd5, 4'hF, 32'h0);
      @(negedge clk); check("stall_vld_0", 32'(a1_rdv), 32'd0); tick();
      @(negedge clk); check("stall_vld_1", 32'(a1_rdv), 32'd0); tick();
      @(negedge clk); check("stall_vld_2", 32'(a1_rdv), 32'd0); tick();
      clken = 1'b1;
      idle_all();
      @(negedge clk);
      check("stall_release_vld", 32'(a1_rdv), 32'd1);
      check("stall_release_dat", a1_rdat, 32'hDEADBEEF);
      tick();
      @(negedge clk); check("stall_once", 32'(a1_rdv), 32'd0); tick();

      // reset_req acts as a stall too
      a1_cmd(1'b1, 1'b0, 12'd6, 4'h0, 32'h0); tick();
      reset_req = 1'b1;
      idle_all();
      @(negedge clk); check("rreq_vld_0", 32'(a1_rdv), 32'd0); tick();
      reset_req = 1'b0;
      @(negedge clk);
      check("rreq_vld", 32'(a1_rdv), 32'd1);
      check("rreq_dat", a1_rdat, 32'hFF22FF44);
      tick();

      // Freeze drops writes on both ports
      freeze = 1'b1;
      a1_cmd(1'b0, 1'b1, 12'd5, 4'hF, 32'h0);
      a2_cmd(1'b0, 1'b1, 12'd6, 4'hF, 32'h0); tick();
      freeze = 1'b0;
      a1_cmd(1'b1, 1'b0, 12'd5, 4'h0, 32'h0);
      a2_cmd(1'b1, 1'b0, 12'd6, 4'h0, 32'h0); tick();
      idle_all();
      @(negedge clk);
      check("freeze_a1", a1_rdat, 32'hDEADBEEF);
      check("freeze_a2", a2_rdat, 32'hFF22FF44);
      tick();

      // Range boundary: 2999 is the last word, 3000 and 3500 are out of range
      a1_cmd(1'b0, 1'b1, 12'd2999, 4'hF, 32'h2999ABCD);
      a2_cmd(1'b0, 1'b1, 12'd3500, 4'hF, 32'h77777777); tick();
      a1_cmd(1'b1, 1'b0, 12'd2999, 4'h0, 32'h0);
      a2_cmd(1'b1, 1'b0, 12'd3500, 4'h0, 32'h0); tick();
      idle_all();
      @(negedge clk);
      check("last_word", a1_rdat, 32'h2999ABCD);
      check("oor_3500_vld", 32'(a2_rdv), 32'd1);
      check("oor_3500_dat", a2_rdat, 32'h0);
      tick();
      a1_cmd(1'b1, 1'b0, 12'd3000, 4'h0, 32'h0); tick();
      idle_all();
      @(negedge clk);
      check("oor_3000_vld", 32'(a1_rdv), 32'd1);
      check("oor_3000_dat", a1_rdat, 32'h0);
      tick();

      // Reset the cycle after an accepted read; a write during reset must be ignored
      a2_cmd(1'b0, 1'b1, 12'd11, 4'hF, 32'h0B0B0B0B); tick();
      a1_cmd(1'b1, 1'b0, 12'd5, 4'h0, 32'h0);
      a2_cmd(1'b0, 1'b0, 12'd0, 4'h0, 32'h0); tick();
      reset = 1'b1;
      a1_cmd(1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
      a2_cmd(1'b0, 1'b1, 12'd11, 4'hF, 32'hFFFFFFFF);
      @(negedge clk); check("flush_vld_in_rst", 32'(a1_rdv), 32'd0); tick();
      reset = 1'b0;
      idle_all();
      @(negedge clk);
      check("flush_vld_after", 32'(a1_rdv), 32'd0);
      check("flush_dat", a1_rdat, 32'h0);
      tick();
      a2_cmd(1'b1, 1'b0, 12'd11, 4'h0, 32'h0); tick();
      idle_all();
      @(negedge clk); check("rst_cmd_ignored", a2_rdat, 32'h0B0B0B0B); tick();

      // Latency 2 instance, back-to-back reads
      b1_cmd(1'b0, 1'b1, 4'd3, 4'hF, 32'h0BADCAFE); tick();
      b1_cmd(1'b0, 1'b1, 4'd4, 4'hF, 32'h44440000); tick();
      b1_cmd(1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
      @(negedge clk); check("l2_issue_vld", 32'(b1_rdv), 32'd0); tick();
      b1_cmd(1'b1, 1'b0, 4'd4, 4'h0, 32'h0);
      @(negedge clk); check("l2_c1_vld", 32'(b1_rdv), 32'd0); tick();
      idle_all();
      @(negedge clk);
      check("l2_c2_vld", 32'(b1_rdv), 32'd1);
      check("l2_c2_dat", b1_rdat, 32'h0BADCAFE);
      tick();
      @(negedge clk);
      check("l2_c3_vld", 32'(b1_rdv), 32'd1);
      check("l2_c3_dat", b1_rdat, 32'h44440000);
      tick();
      @(negedge clk); check("l2_done", 32'(b1_rdv), 32'd0); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
